// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: byte/pair/step/flag write controls, read requests and read results.
// The master drives requests and writes; the slave (the register bank) returns read data and flags.
interface register_bank_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 3,
   parameter int FLAG_WIDTH    = 4
) ();
   logic                      i_wr_en;
   logic [ADDRESS_WIDTH-1:0]  i_wr_addr;
   logic [DATA_WIDTH-1:0]     i_wr_data;
   logic                      i_pair_wr_en;
   logic [1:0]                i_pair_wr_sel;
   logic [2*DATA_WIDTH-1:0]   i_pair_wr_data;
   logic                      i_step_en;
   logic [1:0]                i_step_sel;
   logic                      i_step_dec;
   logic                      i_flag_wr_en;
   logic [FLAG_WIDTH-1:0]     i_flag_data;
   logic                      i_rd0_en;
   logic                      i_rd1_en;
   logic [ADDRESS_WIDTH-1:0]  i_rd0_addr;
   logic [ADDRESS_WIDTH-1:0]  i_rd1_addr;
   logic                      i_prd_en;
   logic [1:0]                i_prd_sel;
   logic [DATA_WIDTH-1:0]     o_rd0_data;
   logic [DATA_WIDTH-1:0]     o_rd1_data;
   logic                      o_rd0_valid;
   logic                      o_rd1_valid;
   logic [2*DATA_WIDTH-1:0]   o_pair_data;
   logic                      o_pair_valid;
   logic [FLAG_WIDTH-1:0]     o_flags;

   modport master (
      output i_wr_en, i_wr_addr, i_wr_data,
      output i_pair_wr_en, i_pair_wr_sel, i_pair_wr_data,
      output i_step_en, i_step_sel, i_step_dec,
      output i_flag_wr_en, i_flag_data,
      output i_rd0_en, i_rd1_en, i_rd0_addr, i_rd1_addr,
      output i_prd_en, i_prd_sel,
      input  o_rd0_data, o_rd1_data, o_rd0_valid, o_rd1_valid,
      input  o_pair_data, o_pair_valid, o_flags
   );

   modport slave (
      input  i_wr_en, i_wr_addr, i_wr_data,
      input  i_pair_wr_en, i_pair_wr_sel, i_pair_wr_data,
      input  i_step_en, i_step_sel, i_step_dec,
      input  i_flag_wr_en, i_flag_data,
      input  i_rd0_en, i_rd1_en, i_rd0_addr, i_rd1_addr,
      input  i_prd_en, i_prd_sel,
      output o_rd0_data, o_rd1_data, o_rd0_valid, o_rd1_valid,
      output o_pair_data, o_pair_valid, o_flags
   );
endinterface

// File: rtl/register_bank.sv
// GB80-style register file: B C D E H L A plus flag register F, with byte and pair access,
// pair increment/decrement, and registered read ports that see same-cycle updates.
module register_bank #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 3,
   parameter int MEM_CODE      = 6,
   parameter int FLAG_WIDTH    = 4
) (
   input logic             i_clk,
   input logic             i_reset,
   register_bank_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int PW = 2 * DATA_WIDTH;

   // Storage index order: B C D E H L A, so pair n occupies indices 2n and 2n+1.
   typedef logic [6:0][W-1:0] regArray_t;

   regArray_t               r_regs;
   logic [FLAG_WIDTH-1:0]   r_flags;
   logic [W-1:0]            r_rd0Data;
   logic [W-1:0]            r_rd1Data;
   logic                    r_rd0Valid;
   logic                    r_rd1Valid;
   logic [PW-1:0]           r_pairData;
   logic                    r_pairValid;

   regArray_t               w_nextRegs;
   logic [FLAG_WIDTH-1:0]   w_nextFlags;
   logic [W-1:0]            w_nextFByte;
   logic [PW-1:0]           w_stepSrc;
   logic [PW-1:0]           w_stepRes;
   logic                    w_stepActive;
   logic [2:0]              w_stepHiIdx;
   logic [2:0]              w_stepLoIdx;
   logic [2:0]              w_pairHiIdx;
   logic [2:0]              w_pairLoIdx;

   function automatic logic [ADDRESS_WIDTH-1:0] codeOf(input int idx);
      return (idx < 6) ? ADDRESS_WIDTH'(idx) : ADDRESS_WIDTH'(7);
   endfunction

   function automatic logic [W-1:0] readByte(input logic [ADDRESS_WIDTH-1:0] code,
                                             input regArray_t regs);
      logic [W-1:0] value;
      value = '0;
      if (code != ADDRESS_WIDTH'(MEM_CODE)) begin
         for (int k = 0; k < 7; k++) begin
            if (code == codeOf(k)) value = regs[k];
         end
      end
      return value;
   endfunction

   function automatic logic [PW-1:0] readPair(input logic [1:0] sel, input regArray_t regs,
                                              input logic [W-1:0] fByte);
      logic [PW-1:0] value;
      case (sel)
         2'd0:    value = {regs[0], regs[1]};
         2'd1:    value = {regs[2], regs[3]};
         2'd2:    value = {regs[4], regs[5]};
         default: value = {regs[6], fByte};
      endcase
      return value;
   endfunction

   // Next-state of every register: byte write, then step, then pair write, each overriding the last.
   always_comb begin
      w_stepHiIdx  = {bus.i_step_sel, 1'b0};
      w_stepLoIdx  = {bus.i_step_sel, 1'b1};
      w_pairHiIdx  = {bus.i_pair_wr_sel, 1'b0};
      w_pairLoIdx  = {bus.i_pair_wr_sel, 1'b1};
      w_stepActive = bus.i_step_en && (bus.i_step_sel != 2'd3);
      w_stepSrc    = readPair(bus.i_step_sel, r_regs, '0);
      w_stepRes    = bus.i_step_dec ? (w_stepSrc - PW'(1)) : (w_stepSrc + PW'(1));

      w_nextRegs = r_regs;
      if (bus.i_wr_en && (bus.i_wr_addr != ADDRESS_WIDTH'(MEM_CODE))) begin
         for (int k = 0; k < 7; k++) begin
            if (bus.i_wr_addr == codeOf(k)) w_nextRegs[k] = bus.i_wr_data;
         end
      end
      if (w_stepActive) begin
         w_nextRegs[w_stepHiIdx] = w_stepRes[PW-1:W];
         w_nextRegs[w_stepLoIdx] = w_stepRes[W-1:0];
      end
      if (bus.i_pair_wr_en) begin
         if (bus.i_pair_wr_sel == 2'd3) begin
            w_nextRegs[6] = bus.i_pair_wr_data[PW-1:W];
         end else begin
            w_nextRegs[w_pairHiIdx] = bus.i_pair_wr_data[PW-1:W];
            w_nextRegs[w_pairLoIdx] = bus.i_pair_wr_data[W-1:0];
         end
      end

      w_nextFlags = r_flags;
      if (bus.i_flag_wr_en) w_nextFlags = bus.i_flag_data;
      if (bus.i_pair_wr_en && (bus.i_pair_wr_sel == 2'd3)) begin
         w_nextFlags = bus.i_pair_wr_data[W-1 -: FLAG_WIDTH];
      end

      w_nextFByte = '0;
      w_nextFByte[W-1 -: FLAG_WIDTH] = w_nextFlags;
   end

   // Read ports sample the post-update values so a same-cycle write is visible immediately.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_regs      <= '0;
         r_flags     <= '0;
         r_rd0Data   <= '0;
         r_rd1Data   <= '0;
         r_rd0Valid  <= 1'b0;
         r_rd1Valid  <= 1'b0;
         r_pairData  <= '0;
         r_pairValid <= 1'b0;
      end else begin
         r_regs      <= w_nextRegs;
         r_flags     <= w_nextFlags;
         r_rd0Valid  <= bus.i_rd0_en;
         r_rd1Valid  <= bus.i_rd1_en;
         r_pairValid <= bus.i_prd_en;
         if (bus.i_rd0_en) r_rd0Data  <= readByte(bus.i_rd0_addr, w_nextRegs);
         if (bus.i_rd1_en) r_rd1Data  <= readByte(bus.i_rd1_addr, w_nextRegs);
         if (bus.i_prd_en) r_pairData <= readPair(bus.i_prd_sel, w_nextRegs, w_nextFByte);
      end
   end

   assign bus.o_rd0_data   = r_rd0Data;
   assign bus.o_rd1_data   = r_rd1Data;
   assign bus.o_rd0_valid  = r_rd0Valid;
   assign bus.o_rd1_valid  = r_rd1Valid;
   assign bus.o_pair_data  = r_pairData;
   assign bus.o_pair_valid = r_pairValid;
   assign bus.o_flags      = r_flags;
endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: hand-computed vectors checked with immediate assertions.
module tb_register_bank;
   localparam int DW = 8;
   localparam int AW = 3;
   localparam int FW = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   register_bank_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FLAG_WIDTH(FW)) bus ();

   register_bank #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_CODE(6), .FLAG_WIDTH(FW)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idleInputs();
      bus.i_wr_en        = 1'b0;
      bus.i_wr_addr      = '0;
      bus.i_wr_data      = '0;
      bus.i_pair_wr_en   = 1'b0;
      bus.i_pair_wr_sel  = '0;
      bus.i_pair_wr_data = '0;
      bus.i_step_en      = 1'b0;
      bus.i_step_sel     = '0;
      bus.i_step_dec     = 1'b0;
      bus.i_flag_wr_en   = 1'b0;
      bus.i_flag_data    = '0;
      bus.i_rd0_en       = 1'b0;
      bus.i_rd1_en       = 1'b0;
      bus.i_rd0_addr     = '0;
      bus.i_rd1_addr     = '0;
      bus.i_prd_en       = 1'b0;
      bus.i_prd_sel      = '0;
   endtask

   // Clock the currently driven inputs in and settle just after the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idleInputs();
      applyStimulus();
      applyStimulus();
      checkOutput("reset_rd0_data", 32'(bus.o_rd0_data), 32'h00);
      checkOutput("reset_rd0_valid", 32'(bus.o_rd0_valid), 32'h0);
      checkOutput("reset_pair_valid", 32'(bus.o_pair_valid), 32'h0);
      checkOutput("reset_flags", 32'(bus.o_flags), 32'h0);
      reset = 1'b0;

      for (int c = 0; c < 8; c++) begin
         idleInputs();
         bus.i_rd0_en = 1'b1; bus.i_rd0_addr = 3'(c);
         bus.i_rd1_en = 1'b1; bus.i_rd1_addr = 3'(c);
         applyStimulus();
         checkOutput($sformatf("reset_read0_code%0d", c), 32'(bus.o_rd0_data), 32'h00);
         checkOutput($sformatf("reset_read1_code%0d", c), 32'(bus.o_rd1_data), 32'h00);
         checkOutput($sformatf("valid0_code%0d", c), 32'(bus.o_rd0_valid), 32'h1);
         checkOutput($sformatf("valid1_code%0d", c), 32'(bus.o_rd1_valid), 32'h1);
      end
      idleInputs();
      applyStimulus();
      checkOutput("valid0_pulse_ends", 32'(bus.o_rd0_valid), 32'h0);
      checkOutput("valid1_pulse_ends", 32'(bus.o_rd1_valid), 32'h0);

      // Byte writes B then C, then pair read BC.
      idleInputs(); bus.i_wr_en = 1'b1; bus.i_wr_addr = 3'd0; bus.i_wr_data = 8'h12;
      applyStimulus();
      idleInputs(); bus.i_wr_en = 1'b1; bus.i_wr_addr = 3'd1; bus.i_wr_data = 8'h34;
      applyStimulus();
      idleInputs(); bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd0;
      applyStimulus();
      checkOutput("pair_bc", 32'(bus.o_pair_data), 32'h1234);
      checkOutput("pair_valid", 32'(bus.o_pair_valid), 32'h1);

      // Memory code swallows writes and reads back zero.
      idleInputs(); bus.i_wr_en = 1'b1; bus.i_wr_addr = 3'd6; bus.i_wr_data = 8'hAA;
      applyStimulus();
      idleInputs();
      bus.i_rd0_en = 1'b1; bus.i_rd0_addr = 3'd6;
      bus.i_rd1_en = 1'b1; bus.i_rd1_addr = 3'd0;
      applyStimulus();
      checkOutput("mem_code_read", 32'(bus.o_rd0_data), 32'h00);
      checkOutput("read_b", 32'(bus.o_rd1_data), 32'h12);

      // HL wrap-around in both directions, plus bypassed reads in the stepping cycle.
      idleInputs(); bus.i_pair_wr_en = 1'b1; bus.i_pair_wr_sel = 2'd2; bus.i_pair_wr_data = 16'hFFFF;
      applyStimulus();
      idleInputs(); bus.i_step_en = 1'b1; bus.i_step_sel = 2'd2;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd2;
      applyStimulus();
      checkOutput("hl_inc_wrap", 32'(bus.o_pair_data), 32'h0000);
      idleInputs(); bus.i_step_en = 1'b1; bus.i_step_sel = 2'd2; bus.i_step_dec = 1'b1;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd2;
      applyStimulus();
      checkOutput("hl_dec_wrap", 32'(bus.o_pair_data), 32'hFFFF);
      idleInputs(); bus.i_pair_wr_en = 1'b1; bus.i_pair_wr_sel = 2'd2; bus.i_pair_wr_data = 16'h8000;
      applyStimulus();
      idleInputs(); bus.i_step_en = 1'b1; bus.i_step_sel = 2'd2; bus.i_step_dec = 1'b1;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd2;
      bus.i_rd0_en = 1'b1; bus.i_rd0_addr = 3'd4;
      applyStimulus();
      checkOutput("hl_dec_borrow", 32'(bus.o_pair_data), 32'h7FFF);
      checkOutput("h_bypass", 32'(bus.o_rd0_data), 32'h7F);

      // Load A and flags, then a step on select 3 must leave AF alone.
      idleInputs(); bus.i_wr_en = 1'b1; bus.i_wr_addr = 3'd7; bus.i_wr_data = 8'h9A;
      bus.i_flag_wr_en = 1'b1; bus.i_flag_data = 4'hC;
      applyStimulus();
      checkOutput("flags_c", 32'(bus.o_flags), 32'hC);
      idleInputs(); bus.i_step_en = 1'b1; bus.i_step_sel = 2'd3;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd3;
      bus.i_rd0_en = 1'b1; bus.i_rd0_addr = 3'd5;
      applyStimulus();
      checkOutput("step_sel3_af", 32'(bus.o_pair_data), 32'h9AC0);
      checkOutput("read_l", 32'(bus.o_rd0_data), 32'hFF);

      // Step outranks a byte write to the same pair.
      idleInputs(); bus.i_step_en = 1'b1; bus.i_step_sel = 2'd1;
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 3'd3; bus.i_wr_data = 8'h22;
      bus.i_rd0_en = 1'b1; bus.i_rd0_addr = 3'd3;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd1;
      applyStimulus();
      checkOutput("step_over_byte_e", 32'(bus.o_rd0_data), 32'h01);
      checkOutput("step_over_byte_de", 32'(bus.o_pair_data), 32'h0001);

      // Pair write outranks step and byte write in the same cycle.
      idleInputs(); bus.i_pair_wr_en = 1'b1; bus.i_pair_wr_sel = 2'd2; bus.i_pair_wr_data = 16'hBEEF;
      bus.i_step_en = 1'b1; bus.i_step_sel = 2'd2;
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 3'd5; bus.i_wr_data = 8'h11;
      bus.i_rd0_en = 1'b1; bus.i_rd0_addr = 3'd5;
      applyStimulus();
      checkOutput("priority_l", 32'(bus.o_rd0_data), 32'hEF);
      idleInputs(); bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd2;
      applyStimulus();
      checkOutput("priority_hl", 32'(bus.o_pair_data), 32'hBEEF);
      checkOutput("rd0_hold_data", 32'(bus.o_rd0_data), 32'hEF);
      checkOutput("rd0_hold_valid", 32'(bus.o_rd0_valid), 32'h0);

      // AF pair write beats a same-cycle flag write; a later flag write lands.
      idleInputs(); bus.i_pair_wr_en = 1'b1; bus.i_pair_wr_sel = 2'd3; bus.i_pair_wr_data = 16'h55FF;
      bus.i_flag_wr_en = 1'b1; bus.i_flag_data = 4'h3;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd3;
      applyStimulus();
      checkOutput("af_pair_write", 32'(bus.o_pair_data), 32'h55F0);
      checkOutput("af_flags", 32'(bus.o_flags), 32'hF);
      idleInputs(); bus.i_flag_wr_en = 1'b1; bus.i_flag_data = 4'h3;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd3;
      applyStimulus();
      checkOutput("flag_write", 32'(bus.o_pair_data), 32'h5530);
      checkOutput("flag_out", 32'(bus.o_flags), 32'h3);

      // Reset overrides a concurrent write and reads.
      idleInputs(); reset = 1'b1;
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 3'd7; bus.i_wr_data = 8'h77;
      bus.i_rd0_en = 1'b1; bus.i_rd0_addr = 3'd7;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd3;
      applyStimulus();
      checkOutput("reset_over_rd0_valid", 32'(bus.o_rd0_valid), 32'h0);
      checkOutput("reset_over_pair_valid", 32'(bus.o_pair_valid), 32'h0);
      checkOutput("reset_over_rd0_data", 32'(bus.o_rd0_data), 32'h00);
      checkOutput("reset_over_flags", 32'(bus.o_flags), 32'h0);
      reset = 1'b0;
      idleInputs(); bus.i_rd0_en = 1'b1; bus.i_rd0_addr = 3'd7;
      bus.i_prd_en = 1'b1; bus.i_prd_sel = 2'd3;
      applyStimulus();
      checkOutput("post_reset_a", 32'(bus.o_rd0_data), 32'h00);
      checkOutput("post_reset_af", 32'(bus.o_pair_data), 32'h0000);
      checkOutput("post_reset_valid", 32'(bus.o_rd0_valid), 32'h1);

      idleInputs();
      applyStimulus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
